// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter in front of a single-port synchronous RAM.
// Each access runs IDLE -> ACCESS -> RESP. The RAM side is fully registered,
// and each master gets a one-cycle ready pulse in RESP.
module mem_arbiter #(
  parameter bit RR = 1'b1  // 1: round-robin, 0: master 0 wins every tie
) (
  input  logic        clk,
  input  logic        resetn,
  // master 0 (processor)
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  input  logic        m0_rstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  // master 1 (loader / debug)
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  input  logic        m1_rstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  // RAM side
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_wmask,
  output logic        ram_rstrb,
  input  logic [31:0] ram_rdata,
  output logic [1:0]  gnt
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;
  logic [3:0]  ram_wmask_q, ram_wmask_d;
  logic        ram_rstrb_q, ram_rstrb_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        last_q, last_d;  // index of the master served most recently

  logic req0, req1, pick1;

  // Requests are level-held until ready, so sampling them only in IDLE loses nothing.
  assign req0 = m0_rstrb | (|m0_wmask);
  assign req1 = m1_rstrb | (|m1_wmask);

  // Master 1 wins when it is alone, or on a round-robin tie after master 0 was served.
  assign pick1 = RR ? (req1 & (~req0 | ~last_q)) : (req1 & ~req0);

  // Byte-lane bits of the address are ignored. The RAM is word-indexed.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{m0_addr[1:0], m1_addr[1:0]};

  // Next-state, RAM-register and grant logic.
  always_comb begin
    state_d     = state_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_wmask_d = ram_wmask_q;
    ram_rstrb_d = ram_rstrb_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          if (pick1) begin
            ram_addr_d  = {m1_addr[31:2], 2'b00};
            ram_wdata_d = m1_wdata;
            ram_wmask_d = m1_wmask;
            ram_rstrb_d = ~(|m1_wmask);  // a write never strobes a read
            gnt_d       = 2'b10;
          end else begin
            ram_addr_d  = {m0_addr[31:2], 2'b00};
            ram_wdata_d = m0_wdata;
            ram_wmask_d = m0_wmask;
            ram_rstrb_d = ~(|m0_wmask);
            gnt_d       = 2'b01;
          end
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // The RAM samples at the end of this cycle. Strobes drop afterwards,
        // while addr/wdata hold their values.
        ram_wmask_d = 4'h0;
        ram_rstrb_d = 1'b0;
        state_d     = RESP;
      end
      RESP: begin
        last_d  = gnt_q[1];
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  // State and RAM-side registers. Reset kills an in-flight write at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_wmask_q <= '0;
      ram_rstrb_q <= 1'b0;
      gnt_q       <= 2'b00;
      last_q      <= 1'b1;  // master 0 wins the first tie
    end else begin
      state_q     <= state_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_wmask_q <= ram_wmask_d;
      ram_rstrb_q <= ram_rstrb_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_wmask = ram_wmask_q;
  assign ram_rstrb = ram_rstrb_q;
  assign gnt       = gnt_q;

  // Ready is decoded from RESP. Reset forces IDLE, so it clears with the state.
  assign m0_ready = (state_q == RESP) & gnt_q[0];
  assign m1_ready = (state_q == RESP) & gnt_q[1];
  assign m0_rdata = ram_rdata;
  assign m1_rdata = ram_rdata;

endmodule
